// File: rtl/io_bus_bridge.sv
// CPU-side bus bridge: zero-wait CODE/DATA memory paths plus a stalling
// handshake to N_IO one-hot IO channels. Optional timeout: IO_BUS_BRIDGE_TIMEOUT_EN.
module io_bus_bridge #(
    parameter int unsigned N_IO        = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] UNMAPPED_RD = 32'h10203040
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [29:0]          CPU_ADDR,
    input  logic                 CPU_REQ,
    input  logic                 CPU_WE,
    input  logic [3:0]           CPU_BE,
    input  logic [31:0]          CPU_WD,
    output logic [31:0]          CPU_RD,
    output logic                 CPU_STALL,
    output logic                 BUS_ERR,
    output logic [29:0]          STACK_MEM_A,
    output logic                 STACK_MEM_WE,
    output logic [3:0]           STACK_MEM_BE,
    output logic [31:0]          STACK_MEM_WD,
    input  logic [31:0]          STACK_MEM_RD,
    output logic [29:0]          CODE_MEM_A,
    output logic                 CODE_MEM_WE,
    output logic [31:0]          CODE_MEM_WD,
    input  logic [31:0]          CODE_MEM_RD,
    output logic [N_IO-1:0]      IO_REQ,
    output logic                 IO_WE,
    output logic [3:0]           IO_BE,
    output logic [31:0]          IO_WD,
    input  logic [32*N_IO-1:0]   IO_RD,
    input  logic [N_IO-1:0]      IO_ACK
);

    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = $clog2(N_IO);

    if (N_IO != 2 && N_IO != 4 && N_IO != 8 && N_IO != 16) begin : g_bad_n_io
        $error("io_bus_bridge: N_IO must be 2, 4, 8 or 16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("io_bus_bridge: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, IO_WAIT, DONE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  sel, sel_next;
    logic [DW-1:0]     rdata, rdata_next;
    logic [N_IO-1:0]   req_next;
    logic              seg_io, seg_code, seg_data, mapped, io_start, mem_open;
    logic              ack_sel;
    logic [DW-1:0]     rd_sel;

`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [DW-1:0] TIMEOUT_RD = 32'hDEADBEEF;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;
`endif

    assign seg_io   = (CPU_ADDR[29:28] == 2'b00);
    assign seg_code = (CPU_ADDR[29:28] == 2'b01);
    assign seg_data = CPU_ADDR[29];
    assign mapped   = (32'(CPU_ADDR[3:0]) < N_IO);
    assign io_start = (state == IDLE) && CPU_REQ && seg_io;
    // Memory writes are only allowed while no IO transaction owns the CPU.
    assign mem_open = (state == IDLE) || !RESET_N;

    assign STACK_MEM_A  = CPU_ADDR;
    assign STACK_MEM_BE = CPU_BE;
    assign STACK_MEM_WD = CPU_WD;
    assign CODE_MEM_A   = CPU_ADDR;
    assign CODE_MEM_WD  = CPU_WD;

    // Next-state, channel select and combinational CPU-side outputs.
    always_comb begin
        state_next   = state;
        sel_next     = sel;
        rdata_next   = rdata;
        req_next     = '0;
        ack_sel      = 1'b0;
        rd_sel       = '0;
        CPU_RD       = rdata;
        CPU_STALL    = 1'b0;
        STACK_MEM_WE = 1'b0;
        CODE_MEM_WE  = 1'b0;
`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif

        for (int k = 0; k < N_IO; k++) begin
            if (sel == IDX_W'(k)) begin
                ack_sel = IO_ACK[k];
                rd_sel  = IO_RD[32*k +: 32];
            end
        end

        case (state)
            IDLE: begin
                if (io_start) begin
                    sel_next = CPU_ADDR[IDX_W-1:0];
                    if (mapped) begin
                        state_next = IO_WAIT;
                    end else begin
                        state_next = DONE;
                        rdata_next = UNMAPPED_RD;
                    end
                end
            end
            IO_WAIT: begin
                if (ack_sel) begin
                    state_next = DONE;
                    rdata_next = rd_sel;
                end
`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next  = DONE;
                    rdata_next  = TIMEOUT_RD;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        for (int k = 0; k < N_IO; k++) begin
            req_next[k] = (state_next == IO_WAIT) && (sel_next == IDX_W'(k));
        end

        if (state != DONE) begin
            if (seg_data)      CPU_RD = STACK_MEM_RD;
            else if (seg_code) CPU_RD = CODE_MEM_RD;
        end

        CPU_STALL    = RESET_N && (io_start || (state == IO_WAIT));
        STACK_MEM_WE = mem_open && CPU_REQ && CPU_WE && seg_data;
        CODE_MEM_WE  = mem_open && CPU_REQ && CPU_WE && seg_code;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= IDLE;
            sel    <= '0;
            rdata  <= '0;
            IO_REQ <= '0;
            IO_WE  <= 1'b0;
            IO_BE  <= '0;
            IO_WD  <= '0;
        end else begin
            state  <= state_next;
            sel    <= sel_next;
            rdata  <= rdata_next;
            IO_REQ <= req_next;
            if (io_start) begin
                IO_WE <= CPU_WE;
                IO_BE <= CPU_BE;
                IO_WD <= CPU_WD;
            end
        end
    end

`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
    // Wait-cycle counter restarts on every entry into IO_WAIT.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt     <= '0;
            BUS_ERR <= 1'b0;
        end else begin
            cnt     <= (state == IO_WAIT && state_next == IO_WAIT) ? cnt + CNT_W'(1) : '0;
            BUS_ERR <= timeout_hit;
        end
    end
`else
    assign BUS_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_bridge.sv
// Randomized self-checking bench for io_bus_bridge against a transaction-level model.
module tb_io_bus_bridge;

    localparam int unsigned N_IO     = 4;
    localparam int unsigned TIMEOUT  = 4;
    localparam logic [31:0] UNMAPPED = 32'h10203040;
`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                CLK;
    logic                RESET_N;
    logic [29:0]         CPU_ADDR;
    logic                CPU_REQ;
    logic                CPU_WE;
    logic [3:0]          CPU_BE;
    logic [31:0]         CPU_WD;
    logic [31:0]         CPU_RD;
    logic                CPU_STALL;
    logic                BUS_ERR;
    logic [29:0]         STACK_MEM_A;
    logic                STACK_MEM_WE;
    logic [3:0]          STACK_MEM_BE;
    logic [31:0]         STACK_MEM_WD;
    logic [31:0]         STACK_MEM_RD;
    logic [29:0]         CODE_MEM_A;
    logic                CODE_MEM_WE;
    logic [31:0]         CODE_MEM_WD;
    logic [31:0]         CODE_MEM_RD;
    logic [N_IO-1:0]     IO_REQ;
    logic                IO_WE;
    logic [3:0]          IO_BE;
    logic [31:0]         IO_WD;
    logic [32*N_IO-1:0]  IO_RD;
    logic [N_IO-1:0]     IO_ACK;

    logic [31:0] chan [N_IO];
    int n_checks = 0;
    int n_errors = 0;

    io_bus_bridge #(.N_IO(N_IO), .TIMEOUT(TIMEOUT), .UNMAPPED_RD(UNMAPPED)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CPU_ADDR(CPU_ADDR), .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_BE(CPU_BE),
        .CPU_WD(CPU_WD), .CPU_RD(CPU_RD), .CPU_STALL(CPU_STALL), .BUS_ERR(BUS_ERR),
        .STACK_MEM_A(STACK_MEM_A), .STACK_MEM_WE(STACK_MEM_WE), .STACK_MEM_BE(STACK_MEM_BE),
        .STACK_MEM_WD(STACK_MEM_WD), .STACK_MEM_RD(STACK_MEM_RD),
        .CODE_MEM_A(CODE_MEM_A), .CODE_MEM_WE(CODE_MEM_WE), .CODE_MEM_WD(CODE_MEM_WD),
        .CODE_MEM_RD(CODE_MEM_RD),
        .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_BE(IO_BE), .IO_WD(IO_WD),
        .IO_RD(IO_RD), .IO_ACK(IO_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_channels();
        for (int k = 0; k < N_IO; k++) begin
            chan[k] = $urandom;
            IO_RD[32*k +: 32] = chan[k];
        end
    endtask

    // One zero-wait CODE/DATA access; expectations come from the segment rules.
    task automatic mem_access(input logic [29:0] addr, input logic req, input logic we);
        logic is_data;
        CPU_ADDR     = addr;
        CPU_REQ      = req;
        CPU_WE       = we;
        CPU_BE       = 4'($urandom);
        CPU_WD       = $urandom;
        STACK_MEM_RD = $urandom;
        CODE_MEM_RD  = $urandom;
        is_data      = addr[29];
        #1;
        check("mem_rd", CPU_RD, is_data ? STACK_MEM_RD : CODE_MEM_RD);
        check("mem_stall", CPU_STALL, 1'b0);
        check("stack_we", STACK_MEM_WE, req & we & is_data);
        check("code_we", CODE_MEM_WE, req & we & ~is_data);
        check("mem_addr", {STACK_MEM_A, CODE_MEM_A}, {addr, addr});
        check("mem_wd", {STACK_MEM_WD, CODE_MEM_WD}, {CPU_WD, CPU_WD});
        check("mem_be", STACK_MEM_BE, CPU_BE);
        tick();
        CPU_REQ = 1'b0;
    endtask

    // One IO transaction; the responder acks on the d-th cycle of IO_REQ (never if d is 0).
    task automatic do_io(input logic [3:0] idx, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int d, input bit ack_all);
        logic [N_IO-1:0] oh;
        bit              mapped, done, viol, memwe, attr_bad, err_early;
        int              stalls, reqc, guard, exp_req;
        logic [31:0]     exp_rd, got_rd;
        logic            got_err, exp_err;

        mapped = (32'(idx) < N_IO);
        oh     = mapped ? (N_IO'(1) << idx) : '0;
        load_channels();
        if (!mapped) begin
            exp_req = 0;               exp_rd = UNMAPPED;     exp_err = 1'b0;
        end else if (TO_EN && (d == 0 || d > int'(TIMEOUT))) begin
            exp_req = int'(TIMEOUT);   exp_rd = 32'hDEADBEEF; exp_err = 1'b1;
        end else begin
            exp_req = d;               exp_rd = chan[idx];    exp_err = 1'b0;
        end

        CPU_ADDR = {2'b00, 24'($urandom), idx};
        CPU_REQ  = 1'b1;
        CPU_WE   = we;
        CPU_BE   = be;
        CPU_WD   = wd;
        done = 0; viol = 0; memwe = 0; attr_bad = 0; err_early = 0;
        stalls = 0; reqc = 0; guard = 0;
        got_rd = '0; got_err = 1'b0;
        while (!done && guard < 200) begin
            guard++;
            if (IO_REQ != '0) begin
                reqc++;
                if (IO_REQ !== oh) viol = 1;
                if (IO_WE !== we || IO_BE !== be || IO_WD !== wd) attr_bad = 1;
            end
            if (IO_REQ != '0 && reqc == d) IO_ACK = ack_all ? '1 : oh;
            else if (IO_REQ == '0)         IO_ACK = N_IO'($urandom);
            else                           IO_ACK = N_IO'($urandom) & ~oh;
            #1;
            if (STACK_MEM_WE || CODE_MEM_WE) memwe = 1;
            if (CPU_STALL) begin
                stalls++;
                if (BUS_ERR) err_early = 1;
            end else begin
                done    = 1;
                got_rd  = CPU_RD;
                got_err = BUS_ERR;
            end
            @(posedge CLK);
            #1;
        end
        CPU_REQ = 1'b0;
        IO_ACK  = '0;
        check("io_completed", done, 1'b1);
        check("io_stall_cycles", stalls, exp_req + 1);
        check("io_req_cycles", reqc, exp_req);
        check("io_req_onehot", viol, 1'b0);
        check("io_attr_stable", attr_bad, 1'b0);
        check("io_mem_we_quiet", memwe, 1'b0);
        check("io_err_early", err_early, 1'b0);
        check("io_rd", got_rd, exp_rd);
        check("io_bus_err", got_err, exp_err);
        check("io_req_after", IO_REQ, '0);
    endtask

    initial begin
        logic [3:0] ridx;
        RESET_N = 1'b0; CPU_ADDR = 30'h0000_0002; CPU_REQ = 1'b1; CPU_WE = 1'b0;
        CPU_BE = 4'hF; CPU_WD = '0; STACK_MEM_RD = '0; CODE_MEM_RD = '0;
        IO_RD = '0; IO_ACK = '0;
        tick();
        tick();
        check("rst_io_req", IO_REQ, '0);
        check("rst_bus_err", BUS_ERR, 1'b0);
        check("rst_stall", CPU_STALL, 1'b0);
        CPU_ADDR = 30'h2000_0010; STACK_MEM_RD = 32'hCAFE0001;
        #1;
        check("rst_mem_path", CPU_RD, 32'hCAFE0001);
        CPU_REQ = 1'b0;
        RESET_N = 1'b1;
        tick();

        // Directed DATA read with fixed values.
        CPU_ADDR = 30'h2000_0010; CPU_REQ = 1'b1; CPU_WE = 1'b0;
        STACK_MEM_RD = 32'hCAFE0001; CODE_MEM_RD = 32'h1111_2222;
        #1;
        check("data_rd_fixed", CPU_RD, 32'hCAFE0001);
        check("data_stall_fixed", CPU_STALL, 1'b0);
        tick();
        CPU_REQ = 1'b0;

        // Stray ACKs while idle must not start anything.
        IO_ACK = '1;
        tick();
        tick();
        check("stray_ack_req", IO_REQ, '0);
        check("stray_ack_stall", CPU_STALL, 1'b0);
        IO_ACK = '0;

        do_io(4'd2, 1'b1, 4'hF, 32'h0000_00A5, 3, 1'b0);
        do_io(4'd7, 1'b0, 4'hF, 32'h0, 2, 1'b0);
        do_io(4'd1, 1'b0, 4'hF, 32'h0, 2, 1'b1);
        do_io(4'd0, 1'b0, 4'h3, 32'h1234_5678, 1, 1'b0);
        do_io(4'd3, 1'b0, 4'hF, 32'h0, 4, 1'b0);
        do_io(4'd3, 1'b0, 4'hF, 32'h0, 9, 1'b0);

        // Reset in the second IO_WAIT cycle aborts the access without a DONE cycle.
        CPU_ADDR = 30'h0000_0001; CPU_REQ = 1'b1; CPU_WE = 1'b0;
        tick();
        check("mid_rst_req1", IO_REQ, 4'b0010);
        tick();
        check("mid_rst_req2", IO_REQ, 4'b0010);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_stall_low", CPU_STALL, 1'b0);
        tick();
        check("mid_rst_req_off", IO_REQ, '0);
        check("mid_rst_stall_off", CPU_STALL, 1'b0);
        CPU_REQ = 1'b0;
        RESET_N = 1'b1;
        tick();
        check("mid_rst_idle_stall", CPU_STALL, 1'b0);
        check("mid_rst_idle_req", IO_REQ, '0);
        do_io(4'd1, 1'b1, 4'hC, 32'hA5A5_0F0F, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem_access({1'b1, 29'($urandom)}, 1'($urandom), 1'($urandom));
                mem_access({2'b01, 28'($urandom)}, 1'($urandom), 1'($urandom));
            end else begin
                ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15))
                                                   : 4'($urandom_range(0, 3));
                do_io(ridx, 1'($urandom), 4'($urandom), $urandom,
                      int'($urandom_range(1, 8)), 1'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
REQ-001 Parameter N_IO, default 4, number of IO channels; legal values 2, 4, 8, 16.
REQ-002 Parameter TIMEOUT, default 255, number of IO wait cycles before abort; legal range 1..65535.
REQ-003 Parameter UNMAPPED_RD, default 32'h10203040, read data returned for an unmapped IO index.
REQ-004 The block has one clock; reset is synchronous and active-low.
REQ-005 Ports: CLK in 1 clock; RESET_N in 1 sync active-low reset; CPU_ADDR in 30 word address; CPU_REQ in 1 access valid; CPU_WE in 1 write; CPU_BE in 4 byte enables; CPU_WD in 32 write data; CPU_RD out 32 read data; CPU_STALL out 1 hold CPU; BUS_ERR out 1 timeout pulse.
REQ-006 Ports: STACK_MEM_A out 30; STACK_MEM_WE out 1; STACK_MEM_BE out 4; STACK_MEM_WD out 32; STACK_MEM_RD in 32; CODE_MEM_A out 30; CODE_MEM_WE out 1; CODE_MEM_WD out 32; CODE_MEM_RD in 32.
REQ-007 Ports: IO_REQ out N_IO one-hot request; IO_WE out 1; IO_BE out 4; IO_WD out 32; IO_RD in 32*N_IO, channel k at bits [32k+31:32k]; IO_ACK in N_IO.

Function
REQ-008 Segment decode on CPU_ADDR[29:28]: 00 IO, 01 CODE, 1x DATA (stack).
REQ-009 CODE/DATA accesses are combinational, zero-wait: CPU_RD = selected memory RD; the selected *_WE = CPU_REQ & CPU_WE; CPU_STALL = 0.
REQ-010 STACK_MEM_A/CODE_MEM_A = CPU_ADDR; *_WD = CPU_WD; STACK_MEM_BE = CPU_BE, always.
REQ-011 IO index = CPU_ADDR[3:0]; an index >= N_IO is unmapped.
REQ-012 FSM states IDLE, IO_WAIT, DONE; the reset state is IDLE.
REQ-013 IDLE with CPU_REQ and an IO segment: CPU_STALL = 1 combinationally; latch index, WE, BE and WD; next state IO_WAIT (mapped) or DONE with rdata = UNMAPPED_RD (unmapped).
REQ-014 IO_WAIT: IO_REQ[index] = 1 registered; IO_WE, IO_BE and IO_WD are driven from the latches and held stable; CPU_STALL = 1; the cycle counter increments each cycle.
REQ-015 IO_WAIT with IO_ACK[index] = 1: capture IO_RD[index] into rdata; next state DONE; IO_REQ drops on the next edge.
REQ-016 DONE: CPU_STALL = 0; CPU_RD = rdata; next state IDLE. The CPU consumes the result in this cycle.
REQ-017 Minimum mapped IO latency is 2 stall cycles (ACK in the first IO_WAIT cycle); an unmapped IO access stalls 1 cycle.
REQ-018 The CPU holds CPU_ADDR, CPU_WE, CPU_BE and CPU_WD stable while CPU_STALL = 1; the block uses only latched values.
REQ-019 IO_ACK bits on non-selected channels, or any IO_ACK outside IO_WAIT, are ignored.
REQ-020 An unmapped IO write is dropped: no IO_REQ, no error.
REQ-021 In IO_WAIT and DONE, STACK_MEM_WE and CODE_MEM_WE are forced to 0.
REQ-022 IO_REQ is at most one-hot at all times.

Reset
REQ-023 At a RESET_N = 0 clock edge: state = IDLE; IO_REQ = 0; rdata = 0; counter = 0; BUS_ERR = 0. This applies mid-transaction too: an outstanding IO_REQ deasserts at that edge and no DONE cycle occurs.
REQ-024 During reset, CPU_STALL = 0 and memory paths stay combinational per REQ-009.

Configuration
REQ-025 Macro IO_BUS_BRIDGE_TIMEOUT_EN, defined: when the counter reaches TIMEOUT in IO_WAIT without an ACK, the block drops IO_REQ, sets rdata = 32'hDEADBEEF, goes to DONE and asserts BUS_ERR = 1 for exactly the DONE cycle.
REQ-026 If an ACK and the timeout occur in the same cycle, the ACK wins (normal completion, no BUS_ERR).
REQ-027 Macro undefined: no counter or timeout logic; IO_WAIT waits indefinitely; BUS_ERR is tied to 0.

Verification
REQ-028 DATA read, CPU_ADDR = 30'h2000_0010, STACK_MEM_RD = 32'hCAFE0001 -> same-cycle CPU_RD = 32'hCAFE0001, CPU_STALL = 0.
REQ-029 IO write to index 2, WD = 32'h0000_00A5, ACK in 3rd IO_WAIT cycle -> IO_REQ = 4'b0100 for 3 cycles, IO_WD = 32'hA5, 4 stall cycles, STACK_MEM_WE/CODE_MEM_WE never set.
REQ-030 IO read of index 7 with N_IO = 4 -> 1 stall cycle, CPU_RD = 32'h10203040, IO_REQ stays 0.
REQ-031 TIMEOUT_EN, TIMEOUT = 4, no ACK -> IO_REQ high 4 cycles, then DONE with CPU_RD = 32'hDEADBEEF and a one-cycle BUS_ERR; a second run with ACK in the 4th cycle -> real data, BUS_ERR = 0.
REQ-032 RESET_N low in the 2nd IO_WAIT cycle -> IO_REQ = 0 and CPU_STALL = 0 after that edge; the next IO access completes normally.
REQ-033 IO_ACK = 4'b1111 while index 1 is pending -> only channel 1 data is returned, and a stray ACK in IDLE has no effect.
